// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit.
// State encoding and default datapath widths.
package mem_access_unit_pkg;

  localparam int MAU_ADDR_W  = 13;
  localparam int MAU_DATA_W  = 8;
  localparam int MAU_TIMEOUT = 15;

  typedef enum logic [1:0] {
    MAU_IDLE    = 2'd0,
    MAU_RD_WAIT = 2'd1,
    MAU_WR_WAIT = 2'd2
  } mau_state_t;

  function automatic int cnt_width(input int max);
    return $clog2(max + 1);
  endfunction

endpackage

// File: rtl/mem_access_unit_wait_counter.sv
// Saturating wait-state counter.
// tc flags the wait cycle whose end reaches MAX.
module wait_counter
  import mem_access_unit_pkg::*;
#(
  parameter int MAX = MAU_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = cnt_width(MAX);
  localparam logic [W-1:0] LAST = W'(MAX - 1);
  localparam logic [W-1:0] TOP  = W'(MAX);

  logic [W-1:0] cnt;

  // count wait cycles, holding at MAX instead of wrapping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && cnt != TOP) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = en && (cnt >= LAST);

endmodule

// File: rtl/mem_access_unit.sv
// Single-word memory read/write sequencer.
// Handles wait states, read capture and timeout abort.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W  = MAU_ADDR_W,
  parameter int DATA_W  = MAU_DATA_W,
  parameter int TIMEOUT = MAU_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  mau_state_t state;
  logic       tc;
  logic       waiting;

  assign waiting = (state != MAU_IDLE);

  wait_counter #(
    .MAX (TIMEOUT)
  ) u_wait_counter (
    .clk (clk),
    .rst (rst),
    .clr (!waiting),
    .en  (waiting),
    .tc  (tc)
  );

  // access sequencer; ack beats timeout in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= MAU_IDLE;
      busy        <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      mem_addr    <= '0;
      mem_re      <= 1'b0;
      mem_we      <= 1'b0;
      mem_wdata   <= '0;
    end else begin
      done        <= 1'b0;
      rdata_valid <= 1'b0;
      unique case (state)
        MAU_IDLE: begin
          if (req_rd || req_wr) begin
            mem_addr  <= addr;
            mem_wdata <= wdata;
            busy      <= 1'b1;
            if (req_rd) begin
              mem_re <= 1'b1;
              state  <= MAU_RD_WAIT;
            end else begin
              mem_we <= 1'b1;
              state  <= MAU_WR_WAIT;
            end
          end
        end
        MAU_RD_WAIT: begin
          if (mem_ack) begin
            mem_re      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            rdata       <= mem_rdata;
            rdata_valid <= 1'b1;
            state       <= MAU_IDLE;
          end else if (tc) begin
            mem_re <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
            err    <= 1'b1;
            state  <= MAU_IDLE;
          end
        end
        MAU_WR_WAIT: begin
          if (mem_ack) begin
            mem_we <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= MAU_IDLE;
          end else if (tc) begin
            mem_we <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
            err    <= 1'b1;
            state  <= MAU_IDLE;
          end
        end
        default: begin
          mem_re <= 1'b0;
          mem_we <= 1'b0;
          busy   <= 1'b0;
          state  <= MAU_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sequences single-word memory reads and writes requested by the multicycle CPU controller.
- Instruction fetch uses the PC as address; data access uses the TR address.
- Drives an external word-addressed memory that acknowledges each access after a variable number of wait states.
- Returns captured read data with a one-cycle valid strobe, holds busy while an access is in flight, and flags accesses that time out.

Parameters:
- ADDR_W, 13, address width in words.
- DATA_W, 8, data word width.
- TIMEOUT, 15, maximum wait cycles for mem_ack before the access is aborted (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_rd  in  1  read request from controller (MEM_read).
- req_wr  in  1  write request from controller (MEM_write).
- addr  in  ADDR_W  access address, already muxed from PC/TR by the controller datapath.
- wdata  in  DATA_W  write data.
- busy  out  1  access in flight; controller must hold its state while high.
- rdata  out  DATA_W  last captured read data (held until the next read completes).
- rdata_valid  out  1  one-cycle pulse when rdata updates.
- done  out  1  one-cycle pulse at completion of any access, read or write.
- err  out  1  sticky timeout flag; cleared only by reset.
- mem_addr  out  ADDR_W  registered address to memory.
- mem_re  out  1  memory read strobe, held until ack.
- mem_we  out  1  memory write strobe, held until ack.
- mem_wdata  out  DATA_W  registered write data.
- mem_rdata  in  DATA_W  memory read data, valid in the cycle mem_ack=1.
- mem_ack  in  1  memory completion, one cycle.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, wait counter 0, and every output 0, including rdata, mem_addr and mem_wdata.
- State IDLE:
  - On a clock edge with req_rd=1 or req_wr=1, latch addr/wdata into mem_addr/mem_wdata and assert mem_re or mem_we plus busy from the next cycle.
  - Then go to RD_WAIT or WR_WAIT.
  - If req_rd and req_wr are both 1, the read wins; the write is ignored and not queued.
- State RD_WAIT / WR_WAIT:
  - mem_re/mem_we and busy stay high; the wait counter increments every cycle.
- On mem_ack=1:
  - Deassert the strobe next cycle.
  - For a read, capture mem_rdata into rdata and pulse rdata_valid.
  - Pulse done, drop busy, and return to IDLE. These outputs are registered and appear the cycle after ack.
  - Minimum latency: request edge to done = 2 cycles (ack in the first wait cycle).
- Timeout:
  - If the counter reaches TIMEOUT without an ack, drop the strobe, set err, and pulse done.
  - For a timed-out read, leave rdata unchanged and do not pulse rdata_valid.
  - Return to IDLE.
- mem_ack while IDLE is ignored.
- Requests that arrive while busy=1 are ignored; the controller is required to hold them until busy falls, and is re-sampled in IDLE.
- Back-to-back: a new request sampled in the cycle done is high starts the next access immediately. Minimum 1-cycle gap on the memory strobe.
- The counter is sized ceil(log2(TIMEOUT+1)) bits and saturates; it never wraps.
- Reset mid-access aborts immediately. The strobes drop asynchronously and no done is issued.

Decomposition:
- Shared defines package: the state encoding (MAU_IDLE, MAU_RD_WAIT, MAU_WR_WAIT) and the default ADDR_W/DATA_W constants used by the controller datapath.
- Sub-module: wait_counter (clear, enable, saturate at TIMEOUT, terminal-count output), instantiated once.

Test Plan:
- Read with 0 wait: req_rd=1, addr=0x0005; ack next cycle with mem_rdata=0xA7 -> mem_re high 1 cycle, rdata=0xA7, rdata_valid and done pulse once, busy low 2 cycles after request.
- Write with 3 waits: req_wr=1, addr=0x1FFF, wdata=0x3C; ack on the 3rd wait cycle -> mem_we high 3 cycles with mem_addr=0x1FFF, mem_wdata=0x3C; done pulse; rdata_valid stays 0.
- Simultaneous req_rd and req_wr at addr=0x0010 -> only mem_re asserts; mem_we stays 0 throughout.
- Timeout: req_rd, never ack, TIMEOUT=15 -> mem_re drops after 15 wait cycles; err=1 and stays 1; done pulses; rdata keeps its previous value (0xA7).
- Reset mid-read: assert rst=0 during RD_WAIT -> all outputs 0 immediately; after release, an IDLE read of 0x0001 acked with 0x55 completes normally.
- Spurious mem_ack in IDLE plus back-to-back reads 0x0002 then 0x0003 -> spurious ack has no effect; two done pulses; rdata ends at the second ack value.
